pwm_decoder: RTL and testbench

- Receive-side counterpart of the PWM DAC generator: measures an incoming PWM waveform and reports its high time and period in sample ticks.
- Sits behind an input pin. Shares the tick-enable scheme of the generator (`en` from a TickCounter), so it decodes a generator's output directly.
- Flags a stuck-high or stuck-low input (duty 100 % / 0 %) through a saturation timeout.

---
 rtl/pwm_decoder_pkg.sv | 17 +
 rtl/pwm_decoder_sync_ff.sv | 28 ++
 rtl/pwm_decoder.sv | 170 +++++++++++++++++
 tb/tb_pwm_decoder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_decoder_pkg.sv
// Shared definitions for the PWM generator/decoder pair: measurement states,
// default counter width and the synchronizer reset level.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } pwm_state_e;

  localparam int unsigned PWM_CNT_NBITS_DEF = 16;

  // Idle-high reset level keeps a high input from looking like a fresh rising edge.
  localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/pwm_decoder_sync_ff.sv
// Multi-flop metastability synchronizer with synchronous active-low reset
// to a configurable level; reusable for any slow asynchronous pin.
module sync_ff
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = SYNC_RST_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift chain; bit 0 takes the raw pin, the top bit is the synchronized copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period of an incoming PWM waveform in en-sample ticks
// and flags an input stuck high or low through a saturating timeout.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned CNT_NBITS   = PWM_CNT_NBITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pwm_in,
  output logic [CNT_NBITS-1:0] high_time,
  output logic [CNT_NBITS-1:0] period,
  output logic                 valid,
  output logic                 stuck_high,
  output logic                 stuck_low
);

  localparam logic [CNT_NBITS-1:0] CNT_MAX = {CNT_NBITS{1'b1}};
  localparam logic [CNT_NBITS-1:0] CNT_ONE = {{(CNT_NBITS-1){1'b0}}, 1'b1};

  pwm_state_e state_q, state_d;
  logic [CNT_NBITS-1:0] hcnt_q, hcnt_d;
  logic [CNT_NBITS-1:0] pcnt_q, pcnt_d;
  logic [CNT_NBITS-1:0] high_time_q, high_time_d;
  logic [CNT_NBITS-1:0] period_q, period_d;
  logic valid_q, valid_d;
  logic stuck_high_q, stuck_high_d;
  logic stuck_low_q, stuck_low_d;
  logic prev_q, prev_d;

  logic sync_s;
  logic rise_s;
  logic fall_s;
  logic [CNT_NBITS-1:0] hcnt_inc_s;
  logic [CNT_NBITS-1:0] pcnt_inc_s;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pwm_in),
    .q_o   (sync_s)
  );

  assign rise_s     = en & sync_s & ~prev_q;
  assign fall_s     = en & ~sync_s & prev_q;
  assign hcnt_inc_s = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_ONE;
  assign pcnt_inc_s = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_ONE;

  // Next-state, counter and report logic; nothing moves on non-en cycles except valid.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    pcnt_d       = pcnt_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    prev_d       = prev_q;

    if (en) begin
      prev_d = sync_s;
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            hcnt_d  = CNT_ONE;
            pcnt_d  = CNT_ONE;
            state_d = ST_HIGH;
          end else begin
            pcnt_d = pcnt_inc_s;
            if (pcnt_inc_s == CNT_MAX) begin
              stuck_high_d = sync_s;
              stuck_low_d  = ~sync_s;
              state_d      = ST_STUCK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_HIGH: begin
          // An edge on the saturating sample wins over the timeout.
          if (fall_s) begin
            pcnt_d  = pcnt_inc_s;
            state_d = ST_LOW;
          end else begin
            hcnt_d = hcnt_inc_s;
            pcnt_d = pcnt_inc_s;
            if (pcnt_inc_s == CNT_MAX) begin
              stuck_high_d = 1'b1;
              state_d      = ST_STUCK;
            end else begin
              state_d = ST_HIGH;
            end
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            high_time_d = hcnt_q;
            period_d    = pcnt_q;
            valid_d     = 1'b1;
            hcnt_d      = CNT_ONE;
            pcnt_d      = CNT_ONE;
            state_d     = ST_HIGH;
          end else begin
            pcnt_d = pcnt_inc_s;
            if (pcnt_inc_s == CNT_MAX) begin
              stuck_low_d = 1'b1;
              state_d     = ST_STUCK;
            end else begin
              state_d = ST_LOW;
            end
          end
        end
        ST_STUCK: begin
          if (rise_s) begin
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            hcnt_d       = CNT_ONE;
            pcnt_d       = CNT_ONE;
            state_d      = ST_HIGH;
          end else begin
            state_d = ST_STUCK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      prev_d = prev_q;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= {CNT_NBITS{1'b0}};
      pcnt_q       <= {CNT_NBITS{1'b0}};
      high_time_q  <= {CNT_NBITS{1'b0}};
      period_q     <= {CNT_NBITS{1'b0}};
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      prev_q       <= SYNC_RST_VAL;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
      prev_q       <= prev_d;
    end
  end

  assign high_time  = high_time_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized bench for pwm_decoder: a loopback PWM generator and raw pin stimulus,
// checked against a timestamp-based reference model of the measurement rules.
module tb_pwm_decoder;

  localparam int CNT_NBITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX         = 255;

  logic       clk = 1'b0;
  logic       rst_n, en, pwm_in;
  logic [7:0] high_time, period;
  logic       valid, stuck_high, stuck_low;

  always #5 clk = ~clk;

  pwm_decoder #(.CNT_NBITS(CNT_NBITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .high_time(high_time), .period(period), .valid(valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Per-clk history of the pin and of reset, used to derive the synchronized sample.
  bit ph[$];
  bit rh[$];

  // Reference model: positions (in en ticks) of the last accepted rise and fall.
  int       m_tick, m_start, m_rise_t, m_fall_t;
  bit       m_stuck, m_prev, m_valid, m_sh, m_sl;
  logic [7:0] m_ht, m_per;

  int gen_cnt, gen_thr, gap_cnt, gap_lo, gap_hi;

  function automatic logic [18:0] dut_vec();
    return {valid, stuck_high, stuck_low, high_time, period};
  endfunction

  function automatic logic [18:0] mdl_vec();
    return {m_valid, m_sh, m_sl, m_ht, m_per};
  endfunction

  function automatic logic [7:0] sat(input int x);
    return (x > MAX) ? 8'd255 : x[7:0];
  endfunction

  function automatic logic next_en();
    if (gap_cnt <= 0) begin
      gap_cnt = $urandom_range(gap_hi, gap_lo);
      return 1'b1;
    end
    gap_cnt--;
    return 1'b0;
  endfunction

  task automatic m_restart();
    m_rise_t = m_tick;
    m_fall_t = -1;
    m_start  = m_tick - 1;
  endtask

  // One clk: drive inputs at negedge, advance the model at posedge, settle #1.
  task automatic cyc(input logic r, input logic e, input logic p);
    int c;
    bit s, rise, fall;
    @(negedge clk);
    rst_n = r; en = e; pwm_in = p;
    ph.push_back(p);
    rh.push_back(r);
    if (ph.size() > 16) begin
      void'(ph.pop_front());
      void'(rh.pop_front());
    end
    c = ph.size() - 1;
    s = ph[c - SYNC_STAGES];
    for (int j = c - SYNC_STAGES; j < c; j++) if (!rh[j]) s = 1'b1;
    @(posedge clk);
    if (!r) begin
      m_tick = 0; m_start = 0; m_rise_t = -1; m_fall_t = -1;
      m_stuck = 0; m_prev = 1; m_valid = 0; m_ht = 8'd0; m_per = 8'd0;
      m_sh = 0; m_sl = 0;
    end else begin
      m_valid = 0;
      if (e) begin
        m_tick++;
        rise = s & ~m_prev;
        fall = ~s & m_prev;
        m_prev = s;
        if (m_stuck) begin
          if (rise) begin m_stuck = 0; m_sh = 0; m_sl = 0; m_restart(); end
        end else if (m_rise_t < 0) begin
          if (rise) m_restart();
          else if (m_tick - m_start >= MAX) begin m_stuck = 1; m_sh = s; m_sl = ~s; end
        end else if (m_fall_t < 0) begin
          if (fall) m_fall_t = m_tick;
          else if (m_tick - m_start >= MAX) begin m_stuck = 1; m_sh = 1; end
        end else begin
          if (rise) begin
            m_ht = sat(m_fall_t - m_rise_t);
            m_per = sat(m_tick - m_rise_t);
            m_valid = 1;
            m_restart();
          end else if (m_tick - m_start >= MAX) begin
            m_stuck = 1; m_sl = 1;
          end
        end
      end
    end
    #1;
  endtask

  // Loopback generator: 15-count ramp, output high while count < threshold.
  task automatic gen_tick(input logic e);
    cyc(1'b1, e, (gen_cnt < gen_thr));
    if (e) gen_cnt = (gen_cnt == 14) ? 0 : gen_cnt + 1;
  endtask

  task automatic test_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL reset_values got %h expected %h", dut_vec(), 19'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, i[0]);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL reset_hold got %h expected %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_loopback();
    int ticks, nv;
    logic e;
    gen_thr = 5; gen_cnt = 0; gap_lo = 2; gap_hi = 5; gap_cnt = 0;
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    ticks = 0; nv = 0;
    while (ticks < 120) begin
      e = next_en();
      gen_tick(e);
      if (e) ticks++;
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL loopback_model t=%0t got %h expected %h", $time, dut_vec(), mdl_vec());
      end
      if (valid) begin
        nv++;
        n_chk++;
        if (high_time !== 8'd5 || period !== 8'd15) begin
          n_fail++; $display("FAIL loopback_value got %0d/%0d expected 5/15", high_time, period);
        end
      end
    end
    n_chk++;
    if (nv < 5 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++; $display("FAIL loopback_count got valids=%0d sh=%b sl=%b expected >=5,0,0", nv, stuck_high, stuck_low);
    end
  endtask

  task automatic test_sweep();
    int ticks, checked, guard;
    bit skip;
    logic e;
    gap_lo = 2; gap_hi = 5;
    for (int thr = 1; thr <= 14; thr++) begin
      guard = 0;
      while (gen_cnt != 0 && guard < 200) begin
        gen_tick(next_en());
        guard++;
      end
      gen_thr = thr; skip = 1; checked = 0; ticks = 0;
      while (ticks < 45) begin
        e = next_en();
        gen_tick(e);
        if (e) ticks++;
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL sweep_model thr=%0d got %h expected %h", thr, dut_vec(), mdl_vec());
        end
        if (valid) begin
          if (skip) skip = 0;
          else begin
            checked++;
            n_chk++;
            if (high_time !== thr[7:0] || period !== 8'd15) begin
              n_fail++; $display("FAIL sweep_value got %0d/%0d expected %0d/15", high_time, period, thr);
            end
          end
        end
      end
      n_chk++;
      if (checked < 2) begin
        n_fail++; $display("FAIL sweep_count thr=%0d got %0d expected >=2", thr, checked);
      end
    end
  endtask

  task automatic test_stuck_low();
    int first, nv;
    gen_thr = 0; gen_cnt = 0; gap_lo = 0; gap_hi = 0; gap_cnt = 0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    first = -1; nv = 0;
    for (int t = 1; t <= 270; t++) begin
      gen_tick(1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stuck_low_model t=%0d got %h expected %h", t, dut_vec(), mdl_vec());
      end
      if (stuck_low && first < 0) first = t;
      if (valid) nv++;
    end
    n_chk++;
    if (first !== 255 || nv !== 0 || stuck_high !== 1'b0) begin
      n_fail++; $display("FAIL stuck_low_timing got tick=%0d valids=%0d sh=%b expected 255,0,0", first, nv, stuck_high);
    end
  endtask

  task automatic test_stuck_high();
    int first, clr_t, val_t, guard;
    logic [7:0] v_ht, v_per;
    gen_thr = 15; gen_cnt = 0; gap_lo = 0; gap_hi = 0; gap_cnt = 0;
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    first = -1;
    for (int t = 1; t <= 265; t++) begin
      gen_tick(1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stuck_high_model t=%0d got %h expected %h", t, dut_vec(), mdl_vec());
      end
      if (stuck_high && first < 0) first = t;
    end
    n_chk++;
    if (first !== 255 || stuck_low !== 1'b0) begin
      n_fail++; $display("FAIL stuck_high_timing got tick=%0d sl=%b expected 255,0", first, stuck_low);
    end
    guard = 0;
    while (gen_cnt != 0 && guard < 20) begin gen_tick(1'b1); guard++; end
    gen_thr = 7; clr_t = -1; val_t = -1; v_ht = 8'd0; v_per = 8'd0;
    for (int t = 1; t <= 60; t++) begin
      gen_tick(1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stuck_release_model t=%0d got %h expected %h", t, dut_vec(), mdl_vec());
      end
      if (!stuck_high && clr_t < 0) clr_t = t;
      if (valid && val_t < 0) begin val_t = t; v_ht = high_time; v_per = period; end
    end
    n_chk++;
    if (clr_t < 0 || val_t < 0 || val_t - clr_t != 15 || v_ht !== 8'd7 || v_per !== 8'd15) begin
      n_fail++; $display("FAIL stuck_release got clr=%0d valid=%0d %0d/%0d expected valid 15 ticks after clear with 7/15",
                         clr_t, val_t, v_ht, v_per);
    end
  endtask

  task automatic test_high_at_reset();
    int lvl[5] = '{1, 0, 1, 0, 1};
    int len[5] = '{20, 10, 8, 4, 5};
    int nv, n;
    logic [7:0] v_ht, v_per;
    logic e;
    gap_lo = 2; gap_hi = 5; gap_cnt = 0;
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    nv = 0; v_ht = 8'd0; v_per = 8'd0;
    for (int sg = 0; sg < 5; sg++) begin
      n = 0;
      while (n < len[sg]) begin
        e = next_en();
        cyc(1'b1, e, lvl[sg][0]);
        if (e) n++;
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL high_at_reset_model seg=%0d got %h expected %h", sg, dut_vec(), mdl_vec());
        end
        if (valid) begin nv++; v_ht = high_time; v_per = period; end
      end
    end
    n_chk++;
    if (nv !== 1 || v_ht !== 8'd8 || v_per !== 8'd12) begin
      n_fail++; $display("FAIL high_at_reset got valids=%0d %0d/%0d expected 1 valid 8/12", nv, v_ht, v_per);
    end
  endtask

  task automatic test_reset_mid();
    int guard, ticks, nv;
    bit seen;
    logic e;
    gen_thr = 5; gen_cnt = 0; gap_lo = 2; gap_hi = 5; gap_cnt = 0;
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    guard = 0; seen = 0;
    while (!(seen && m_rise_t >= 0 && m_fall_t < 0 && !m_stuck) && guard < 600) begin
      gen_tick(next_en());
      if (valid) seen = 1;
      guard++;
    end
    n_chk++;
    if (guard >= 600) begin
      n_fail++; $display("FAIL reset_mid_reach got timeout expected high phase after a valid");
    end
    cyc(1'b0, 1'b0, (gen_cnt < gen_thr));
    n_chk++;
    if (dut_vec() !== 19'd0) begin
      n_fail++; $display("FAIL reset_mid_clear got %h expected %h", dut_vec(), 19'd0);
    end
    ticks = 0; nv = 0;
    while (ticks < 75) begin
      e = next_en();
      gen_tick(e);
      if (e) ticks++;
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL reset_mid_model got %h expected %h", dut_vec(), mdl_vec());
      end
      if (valid) begin
        nv++;
        n_chk++;
        if (high_time !== 8'd5 || period !== 8'd15) begin
          n_fail++; $display("FAIL reset_mid_value got %0d/%0d expected 5/15", high_time, period);
        end
      end
    end
    n_chk++;
    if (nv < 3) begin
      n_fail++; $display("FAIL reset_mid_count got %0d expected >=3", nv);
    end
  endtask

  task automatic test_random();
    int hold;
    logic lvl, r;
    gap_lo = 0; gap_hi = 3; gap_cnt = 0; hold = 0; lvl = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        lvl = $urandom_range(1, 0);
        hold = $urandom_range(40, 1);
      end
      hold--;
      r = ($urandom_range(199, 0) != 0);
      cyc(r, next_en(), lvl);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_model i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0;
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      ph.push_back(1'b1);
      rh.push_back(1'b0);
    end
    test_reset();
    test_loopback();
    test_sweep();
    test_stuck_low();
    test_stuck_high();
    test_high_at_reset();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule
